// File: rtl/ctrl_bus_if.sv
// Control bus for the multi-cycle MIPS controller: single clock plus
// synchronous active-high reset shared by the control unit and its driver.
interface ctrl_bus_if (
    input logic clk
);
    logic reset;

    // Consumer side: the control unit only samples clock and reset.
    modport central (input clk, input reset);
    modport slave   (input clk, input reset);
    // Producer side: whoever owns reset sequencing.
    modport master  (input clk, output reset);
endinterface

// File: rtl/mc_controller.sv
// Main control unit of the multi-cycle MIPS core. Sequences each instruction
// through fetch/decode/execute/memory/write-back, one state per clock, and
// drives the datapath enables and selects as a Moore decode of the state.
// Also stalls on mem_ready, counts retired instructions and flags illegal
// opcodes/functs.
module mc_controller #(
    parameter bit USE_MEM_READY = 1'b1,
    parameter int CNT_W         = 32
) (
    ctrl_bus_if.central     ctrl_bus,
    input  logic [5:0]      op,
    input  logic [5:0]      funct,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_en,
    output logic            ireg_write_enab,
    output logic            i_or_d,
    output logic            mem_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      pc_src,
    output logic [2:0]      alu_ctrl_sig,
    output logic [CNT_W-1:0] retired,
    output logic            illegal
);

    // Opcodes understood by the core.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes.
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation encodings.
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               illegal_q, illegal_d;
    logic               set_illegal;
    logic               mem_rdy;

    // With the handshake disabled, every access completes in one cycle.
    assign mem_rdy = USE_MEM_READY ? mem_ready : 1'b1;

    // Next-state and Moore output decode; reset suppresses every write strobe.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d         = state_q;
        set_illegal     = 1'b0;
        pc_en           = 1'b0;
        ireg_write_enab = 1'b0;
        i_or_d          = 1'b0;
        mem_write       = 1'b0;
        reg_dst         = 1'b0;
        mem_to_reg      = 1'b0;
        reg_write       = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        pc_src          = 2'b00;
        alu_ctrl_sig    = 3'b000;

        unique case (state_q)
            S_FETCH: begin
                alu_src_b    = 2'b01;
                alu_ctrl_sig = ALU_ADD;
                if (mem_rdy) begin
                    ireg_write_enab = 1'b1;
                    pc_en           = 1'b1;
                    state_d         = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here while the opcode decodes.
                alu_src_b    = 2'b11;
                alu_ctrl_sig = ALU_ADD;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        set_illegal = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                alu_ctrl_sig = ALU_ADD;
                state_d      = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                i_or_d = 1'b1;
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                // Strobe is held for the whole access, not just the ready cycle.
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                if (mem_rdy) state_d = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                case (funct)
                    FN_ADD:  alu_ctrl_sig = ALU_ADD;
                    FN_SUB:  alu_ctrl_sig = ALU_SUB;
                    FN_AND:  alu_ctrl_sig = ALU_AND;
                    FN_OR:   alu_ctrl_sig = ALU_OR;
                    FN_SLT:  alu_ctrl_sig = ALU_SLT;
                    default: begin
                        alu_ctrl_sig = ALU_ADD;
                        set_illegal  = 1'b1;
                    end
                endcase
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = 1'b1;
                alu_ctrl_sig = ALU_SUB;
                pc_src       = 2'b01;
                pc_en        = zero;
                state_d      = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                alu_ctrl_sig = ALU_ADD;
                state_d      = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src  = 2'b10;
                pc_en   = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // An instruction interrupted by reset must not write anything.
        if (ctrl_bus.reset) begin
            pc_en           = 1'b0;
            ireg_write_enab = 1'b0;
            mem_write       = 1'b0;
            reg_write       = 1'b0;
        end
    end

    // Counter and sticky-flag next values: retire on any return to FETCH.
    always_comb begin
        retired_d = retired_q;
        illegal_d = illegal_q | set_illegal;
        if ((state_d == S_FETCH) && (state_q != S_FETCH))
            retired_d = retired_q + 1'b1;
    end

    // State, retired counter and illegal flag registers with synchronous reset.
    always_ff @(posedge ctrl_bus.clk) begin
        // NOTE: non-blocking assignments keep every register updating from
        // the same pre-edge values, independent of statement order.
        if (ctrl_bus.reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    assign retired = retired_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed testbench for mc_controller. Outputs are checked 1 time unit after
// the falling edge; inputs change at the same point so they are stable well
// before the next rising edge.
module tb_mc_controller;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BAD   = 6'b111111;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_BAD   = 6'b111111;

    logic        clk = 1'b0;
    logic [5:0]  op, funct;
    logic        zero, mem_ready;

    logic        pc_en, ireg_write_enab, i_or_d, mem_write, reg_dst;
    logic        mem_to_reg, reg_write, alu_src_a, illegal;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_ctrl_sig;
    logic [31:0] retired;

    logic        w_pc_en, w_ireg_write_enab, w_i_or_d, w_mem_write, w_reg_dst;
    logic        w_mem_to_reg, w_reg_write, w_alu_src_a, w_illegal;
    logic [1:0]  w_alu_src_b, w_pc_src;
    logic [2:0]  w_alu_ctrl_sig;
    logic [3:0]  w_retired;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_ret   = 0;

    always #5 clk = ~clk;

    ctrl_bus_if bus (.clk(clk));

    mc_controller #(.USE_MEM_READY(1'b1), .CNT_W(32)) dut (
        .ctrl_bus(bus), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .ireg_write_enab(ireg_write_enab), .i_or_d(i_or_d),
        .mem_write(mem_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .alu_ctrl_sig(alu_ctrl_sig), .retired(retired),
        .illegal(illegal)
    );

    // Narrow-counter instance sharing the same stimulus, used for wrap-around.
    mc_controller #(.USE_MEM_READY(1'b1), .CNT_W(4)) dut_w (
        .ctrl_bus(bus), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_en(w_pc_en), .ireg_write_enab(w_ireg_write_enab), .i_or_d(w_i_or_d),
        .mem_write(w_mem_write), .reg_dst(w_reg_dst), .mem_to_reg(w_mem_to_reg),
        .reg_write(w_reg_write), .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b),
        .pc_src(w_pc_src), .alu_ctrl_sig(w_alu_ctrl_sig), .retired(w_retired),
        .illegal(w_illegal)
    );

    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    // Advance from FETCH until the next FETCH (alu_src_b==01 only in FETCH).
    task automatic run_until_fetch(output int cycles);
        cycles = 0;
        do begin
            next_cyc();
            cycles++;
        end while (alu_src_b !== 2'b01 && cycles < 20);
    endtask

    task automatic test_reset();
        bus.reset = 1'b1; mem_ready = 1'b1; op = OP_RTYPE; funct = 6'd0; zero = 1'b0;
        next_cyc();
        total_cnt++; if (pc_en !== 1'b0) $display("FAIL rst_pc_en: got %0b want 0", pc_en); else pass_cnt++;
        total_cnt++; if (ireg_write_enab !== 1'b0) $display("FAIL rst_ireg: got %0b want 0", ireg_write_enab); else pass_cnt++;
        next_cyc();
        total_cnt++; if (retired !== 32'd0) $display("FAIL rst_retired: got %0d want 0", retired); else pass_cnt++;
        total_cnt++; if (illegal !== 1'b0) $display("FAIL rst_illegal: got %0b want 0", illegal); else pass_cnt++;
        bus.reset = 1'b0;
        #1;
        total_cnt++; if ({pc_en, ireg_write_enab} !== 2'b11) $display("FAIL fetch_strobes: got %b want 11", {pc_en, ireg_write_enab}); else pass_cnt++;
        total_cnt++; if (alu_src_b !== 2'b01) $display("FAIL fetch_srcb: got %b want 01", alu_src_b); else pass_cnt++;
        total_cnt++; if (alu_ctrl_sig !== 3'b010) $display("FAIL fetch_alu: got %b want 010", alu_ctrl_sig); else pass_cnt++;
        exp_ret = 0;
    endtask

    task automatic test_lw_wait();
        int wr = 0;
        op = OP_LW; mem_ready = 1'b1;
        if (reg_write === 1'b1) wr++;
        next_cyc();  // DECODE
        if (reg_write === 1'b1) wr++;
        total_cnt++; if (alu_src_b !== 2'b11) $display("FAIL lw_decode_srcb: got %b want 11", alu_src_b); else pass_cnt++;
        next_cyc();  // MEMADR
        if (reg_write === 1'b1) wr++;
        total_cnt++; if ({alu_src_a, alu_src_b} !== 3'b110) $display("FAIL lw_memadr: got %b want 110", {alu_src_a, alu_src_b}); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            next_cyc();  // MEMRD, stalled
            mem_ready = 1'b0;
            #1;
            if (reg_write === 1'b1) wr++;
            total_cnt++; if ({i_or_d, mem_to_reg} !== 2'b10) $display("FAIL lw_memrd_wait%0d: got %b want 10", i, {i_or_d, mem_to_reg}); else pass_cnt++;
        end
        next_cyc();  // MEMRD, ready
        mem_ready = 1'b1;
        #1;
        if (reg_write === 1'b1) wr++;
        next_cyc();  // MEMWB
        if (reg_write === 1'b1) wr++;
        total_cnt++; if ({reg_dst, mem_to_reg, reg_write} !== 3'b011) $display("FAIL lw_memwb: got %b want 011", {reg_dst, mem_to_reg, reg_write}); else pass_cnt++;
        total_cnt++; if (retired !== 32'(exp_ret)) $display("FAIL lw_ret_early: got %0d want %0d", retired, exp_ret); else pass_cnt++;
        next_cyc();  // FETCH after 8 cycles
        exp_ret++;
        total_cnt++; if (retired !== 32'(exp_ret)) $display("FAIL lw_retired: got %0d want %0d", retired, exp_ret); else pass_cnt++;
        total_cnt++; if (wr !== 1) $display("FAIL lw_write_count: got %0d want 1", wr); else pass_cnt++;
        total_cnt++; if (alu_src_b !== 2'b01) $display("FAIL lw_back_fetch: got %b want 01", alu_src_b); else pass_cnt++;
    endtask

    task automatic test_rtype_sub();
        op = OP_RTYPE; funct = FN_SUB;
        next_cyc();  // DECODE
        next_cyc();  // EXEC
        total_cnt++; if (alu_ctrl_sig !== 3'b110) $display("FAIL sub_alu: got %b want 110", alu_ctrl_sig); else pass_cnt++;
        total_cnt++; if ({alu_src_a, alu_src_b} !== 3'b100) $display("FAIL sub_srcs: got %b want 100", {alu_src_a, alu_src_b}); else pass_cnt++;
        next_cyc();  // ALUWB
        total_cnt++; if ({reg_dst, mem_to_reg, reg_write} !== 3'b101) $display("FAIL sub_aluwb: got %b want 101", {reg_dst, mem_to_reg, reg_write}); else pass_cnt++;
        next_cyc();  // FETCH
        exp_ret++;
        total_cnt++; if ({alu_src_b, retired} !== {2'b01, 32'(exp_ret)}) $display("FAIL sub_done: got srcb=%b ret=%0d want 01/%0d", alu_src_b, retired, exp_ret); else pass_cnt++;
    endtask

    task automatic test_branch();
        op = OP_BEQ; zero = 1'b1;
        next_cyc();  // DECODE
        next_cyc();  // BRANCH taken
        total_cnt++; if ({pc_en, pc_src, alu_ctrl_sig} !== 6'b1_01_110) $display("FAIL beq_taken: got %b want 101110", {pc_en, pc_src, alu_ctrl_sig}); else pass_cnt++;
        next_cyc();  // FETCH
        exp_ret++;
        total_cnt++; if ({alu_src_b, retired} !== {2'b01, 32'(exp_ret)}) $display("FAIL beq1_done: got srcb=%b ret=%0d want 01/%0d", alu_src_b, retired, exp_ret); else pass_cnt++;
        zero = 1'b0;
        next_cyc();  // DECODE
        next_cyc();  // BRANCH not taken
        total_cnt++; if ({pc_en, pc_src} !== 3'b0_01) $display("FAIL beq_not_taken: got %b want 001", {pc_en, pc_src}); else pass_cnt++;
        next_cyc();  // FETCH
        exp_ret++;
        total_cnt++; if ({alu_src_b, retired} !== {2'b01, 32'(exp_ret)}) $display("FAIL beq2_done: got srcb=%b ret=%0d want 01/%0d", alu_src_b, retired, exp_ret); else pass_cnt++;
    endtask

    task automatic test_illegal();
        op = OP_BAD;
        next_cyc();  // DECODE
        total_cnt++; if (illegal !== 1'b0) $display("FAIL ill_early: got %b want 0", illegal); else pass_cnt++;
        next_cyc();  // FETCH
        exp_ret++;
        total_cnt++; if ({illegal, alu_src_b} !== 3'b1_01) $display("FAIL ill_set: got %b want 101", {illegal, alu_src_b}); else pass_cnt++;
        total_cnt++; if (retired !== 32'(exp_ret)) $display("FAIL ill_retired: got %0d want %0d", retired, exp_ret); else pass_cnt++;
        op = OP_J;
        next_cyc();  // DECODE
        next_cyc();  // JUMP
        total_cnt++; if ({pc_en, pc_src} !== 3'b1_10) $display("FAIL jump_out: got %b want 110", {pc_en, pc_src}); else pass_cnt++;
        next_cyc();  // FETCH after 3 cycles
        exp_ret++;
        total_cnt++; if ({illegal, alu_src_b, retired} !== {1'b1, 2'b01, 32'(exp_ret)}) $display("FAIL jump_done: got ill=%b srcb=%b ret=%0d want 1/01/%0d", illegal, alu_src_b, retired, exp_ret); else pass_cnt++;
    endtask

    task automatic test_reset_memwr();
        op = OP_SW; mem_ready = 1'b1;
        next_cyc();  // DECODE
        next_cyc();  // MEMADR
        next_cyc();  // MEMWR
        mem_ready = 1'b0;
        #1;
        total_cnt++; if ({i_or_d, mem_write} !== 2'b11) $display("FAIL sw_wait: got %b want 11", {i_or_d, mem_write}); else pass_cnt++;
        next_cyc();  // still MEMWR, reset arrives
        bus.reset = 1'b1;
        #1;
        total_cnt++; if (mem_write !== 1'b0) $display("FAIL rst_memwr: got %b want 0", mem_write); else pass_cnt++;
        next_cyc();  // FETCH, reset released here
        bus.reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        exp_ret = 0;
        total_cnt++; if ({alu_src_b, pc_en} !== 3'b01_1) $display("FAIL rst_to_fetch: got %b want 011", {alu_src_b, pc_en}); else pass_cnt++;
        total_cnt++; if ({retired, w_retired, illegal} !== {32'd0, 4'd0, 1'b0}) $display("FAIL rst_clears: got ret=%0d wret=%0d ill=%b want 0/0/0", retired, w_retired, illegal); else pass_cnt++;
    endtask

    task automatic test_wrap();
        int n;
        int lat_err = 0;
        op = OP_J;
        for (int i = 0; i < 16; i++) begin
            run_until_fetch(n);
            if (n != 3) lat_err++;
            exp_ret++;
            if (i == 14) begin
                total_cnt++; if (w_retired !== 4'hF) $display("FAIL wrap_15: got %0d want 15", w_retired); else pass_cnt++;
            end
        end
        total_cnt++; if (lat_err !== 0) $display("FAIL j_latency: got %0d bad runs want 0", lat_err); else pass_cnt++;
        total_cnt++; if (w_retired !== 4'd0) $display("FAIL wrap_zero: got %0d want 0", w_retired); else pass_cnt++;
        total_cnt++; if (retired !== 32'(exp_ret)) $display("FAIL wide_16: got %0d want %0d", retired, exp_ret); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int n;
        op = OP_SW;
        run_until_fetch(n);
        total_cnt++; if (n !== 4) $display("FAIL sw_latency: got %0d want 4", n); else pass_cnt++;
        op = OP_ADDI;
        run_until_fetch(n);
        total_cnt++; if (n !== 4) $display("FAIL addi_latency: got %0d want 4", n); else pass_cnt++;
        op = OP_RTYPE; funct = FN_BAD;
        total_cnt++; if (illegal !== 1'b0) $display("FAIL funct_pre: got %b want 0", illegal); else pass_cnt++;
        run_until_fetch(n);
        exp_ret += 3;
        total_cnt++; if ({illegal, 8'(n)} !== {1'b1, 8'd4}) $display("FAIL bad_funct: got ill=%b lat=%0d want 1/4", illegal, n); else pass_cnt++;
        total_cnt++; if (retired !== 32'(exp_ret)) $display("FAIL b2b_retired: got %0d want %0d", retired, exp_ret); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_lw_wait();
        test_rtype_sub();
        test_branch();
        test_illegal();
        test_reset_memwr();
        test_wrap();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Main control unit of the multi-cycle MIPS core. It sits directly beside the datapath and consumes its decoded op/funct and ALU zero flag.
- It sequences each instruction through fetch, decode, execute, memory and write-back states, one state per clock. Each state drives the datapath enables and selects.
- It stalls on a memory-ready handshake, counts retired instructions and flags illegal opcodes.

Parameters:
- USE_MEM_READY, 1, 1 = FETCH/MEMRD/MEMWR wait for mem_ready; 0 = memory always treated as ready.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- ctrl_bus  ctrl_bus_if.central  -  carries ctrl_bus.clk (single clock) and ctrl_bus.reset (synchronous, active-high).
- op  input  OPECODE  decoded opcode from the datapath.
- funct  input  FUNCT  decoded R-type function.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- pc_en  output  1  PC register write enable.
- ireg_write_enab  output  1  instruction register load.
- i_or_d  output  1  memory address select: 0 = pc, 1 = alu_out.
- mem_write  output  1  memory write strobe.
- reg_dst  output  1  destination select: 0 = rt, 1 = rd.
- mem_to_reg  output  1  write-back select: 0 = alu_out, 1 = read_data.
- reg_write  output  1  register-file write enable.
- alu_src_a  output  1  ALU A select: 0 = pc, 1 = rs.
- alu_src_b  output  2  ALU B select: 00 = rt, 01 = 4, 10 = imm, 11 = imm<<2.
- pc_src  output  2  next-PC select: 00 = alu result, 01 = alu_out reg, 10 = jump target.
- alu_ctrl_sig  output  3  ALU operation code.
- retired  output  CNT_W  count of completed instructions.
- illegal  output  1  sticky flag: an unsupported opcode was decoded.

Behaviour:
- Reset: synchronous, ctrl_bus.reset high at posedge.
  - State goes to FETCH.
  - retired = 0 and illegal = 0.
  - While reset is asserted, all strobes (pc_en, ireg_write_enab, mem_write, reg_write) are forced to 0.
  - Reset mid-instruction aborts it with no further writes.
- Output defaults: every output is 0 except in the states listed below. Outputs are a Moore decode of the state, except pc_en in BRANCH and the mem_ready gating.
- ALU codes: add = 010, sub = 110, and = 000, or = 001, slt = 111.
- States and actions:
  - FETCH: i_or_d=0, alu_src_a=0, alu_src_b=01, add, pc_src=00. ireg_write_enab and pc_en are asserted only when the memory is ready; next state DECODE. If not ready, stay in FETCH with both strobes low.
  - DECODE: alu_src_a=0, alu_src_b=11, add (branch target precomputed).
    - LW/SW go to MEMADR; RTYPE to EXEC; BEQ to BRANCH; ADDI to ADDIEX; J to JUMP.
    - Any other opcode sets illegal, increments retired and goes to FETCH.
  - MEMADR: alu_src_a=1, alu_src_b=10, add. LW goes to MEMRD, SW to MEMWR.
  - MEMRD: i_or_d=1. Leaves for MEMWB when memory is ready, else waits.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
  - MEMWR: i_or_d=1, mem_write asserted while waiting. Goes to FETCH on the ready cycle.
  - EXEC: alu_src_a=1, alu_src_b=00. Funct maps ADD/SUB/AND/OR/SLT to their ALU codes; any other funct uses add and sets illegal. Next state ALUWB.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_en=zero -> FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, add -> ADDIWB.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
  - JUMP: pc_src=10, pc_en=1 -> FETCH.
- Latency with no waits: LW 5 cycles; SW 4; R-type 4; ADDI 4; BEQ 3; J 3; illegal opcode 2.
- retired increments by 1 on the cycle that transitions into FETCH from any state other than FETCH. It wraps modulo 2^CNT_W.
- illegal stays at 1 until reset.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 -> FETCH; first cycle pc_en=1, ireg_write_enab=1, alu_src_b=01, alu_ctrl_sig=010; retired=0.
- LW with mem_ready low 3 cycles in MEMRD -> MEMRD held 3 extra cycles, reg_write=1 with mem_to_reg=1 exactly once, retired +1 after 8 cycles total.
- RTYPE with funct SUB -> EXEC drives 110, ALUWB has reg_dst=1 and reg_write=1, 4 cycles total.
- BEQ with zero=1 and then BEQ with zero=0 -> pc_en=1 with pc_src=01 in the first BRANCH state, pc_en=0 in the second; 3 cycles each.
- Unsupported opcode -> illegal=1 from the cycle after DECODE, state returns to FETCH; a subsequent J still completes in 3 cycles with pc_src=10.
- Reset asserted during MEMWR -> mem_write=0 that cycle, next state FETCH, retired=0; CNT_W=4 with 16 J instructions -> retired wraps to 0.
